uart_tx_arbiter: RTL and testbench

Shares the single UART transmitter between several byte-stream requesters inside main, e.g. a button-event reporter, an RX echo path and a status dumper. It grants the transmitter per packet, not per byte, so each message is sent whole and in order. Grants rotate round-robin between requesters. A hold-timeout watchdog releases the transmitter if the granted requester stalls mid-packet. The block sits between the requester logic and the UART TX byte interface, in the sysclk domain.

---
 rtl/uart_arb_pkg.sv | 15 +
 rtl/rr_priority_pick.sv | 26 ++
 rtl/uart_tx_arbiter.sv | 112 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the packet-granular UART TX arbiter.
package uart_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int UART_BYTE_W = 8;

  function automatic int rr_next(input int ptr, input int n);
    return (ptr + 1) % n;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping modulo N.
module rr_priority_pick
  import uart_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  // Scan from the farthest offset down so the nearest hit to ptr wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        found = 1'b1;
        idx   = IW'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Grants the UART transmitter to one requester per packet, round-robin, with a
// hold-timeout watchdog that releases a requester stalling mid-packet.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int HOLD_TIMEOUT = 12000,
  parameter int DATA_W       = UART_BYTE_W
) (
  input  logic                      sysclk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_valid,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_ready,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                      busy,
  output logic                      timeout_pulse
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int HC_W = (HOLD_TIMEOUT > 0) ? $clog2(HOLD_TIMEOUT + 1) : 1;
  localparam logic [HC_W-1:0] HC_MAX   = '1;
  localparam logic [HC_W-1:0] HC_LIMIT = HC_W'((HOLD_TIMEOUT > 0) ? HOLD_TIMEOUT - 1 : 0);

  arb_state_e      state, state_nxt;
  logic [ID_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [ID_W-1:0] grant_nxt;
  logic [HC_W-1:0] hold_cnt, hold_nxt;
  logic            pulse_nxt;
  logic            pick_found;
  logic [ID_W-1:0] pick_idx;
  logic            g_valid, g_last, xfer, expire;

  rr_priority_pick #(.N(NUM_REQ), .IW(ID_W)) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign g_valid = req_valid[grant_id];
  assign g_last  = req_last[grant_id];
  assign xfer    = (state == GRANT) && g_valid && tx_ready;
  // Only requester silence counts toward expiry; a downstream stall never does.
  assign expire  = (HOLD_TIMEOUT != 0) && (state == GRANT) && !g_valid && (hold_cnt == HC_LIMIT);
  assign busy    = (state == GRANT);

  always_comb begin
    tx_valid  = 1'b0;
    tx_data   = '0;
    req_ready = '0;
    if (state == GRANT) begin
      tx_valid            = g_valid;
      tx_data             = req_data[grant_id*DATA_W +: DATA_W];
      req_ready[grant_id] = tx_ready;
    end
  end

  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    grant_nxt  = grant_id;
    hold_nxt   = hold_cnt;
    pulse_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt = GRANT;
          grant_nxt = pick_idx;
          hold_nxt  = '0;
        end
      end
      GRANT: begin
        if (xfer) begin
          hold_nxt = '0;
          if (g_last) begin
            state_nxt  = IDLE;
            rr_ptr_nxt = ID_W'(rr_next(int'(grant_id), NUM_REQ));
          end
        end else if (expire) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = ID_W'(rr_next(int'(grant_id), NUM_REQ));
          pulse_nxt  = 1'b1;
        end else if (!g_valid && (hold_cnt != HC_MAX)) begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      grant_id      <= '0;
      hold_cnt      <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      state         <= state_nxt;
      rr_ptr        <= rr_ptr_nxt;
      grant_id      <= grant_nxt;
      hold_cnt      <= hold_nxt;
      timeout_pulse <= pulse_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random traffic, every cycle checked against a packet-level model.
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int T = 16;
  localparam int W = 8;

  logic          sysclk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_last = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]  req_ready;
  logic          tx_valid;
  logic [W-1:0]  tx_data;
  logic          tx_ready = 1'b0;
  logic [1:0]    grant_id;
  logic          busy;
  logic          timeout_pulse;

  int errors = 0;
  int checks = 0;

  // Model: owner is -1 when nobody holds the transmitter.
  int m_owner = -1;
  int m_gid = 0;
  int m_ptr = 0;
  int m_silent = 0;
  bit m_pulse = 1'b0;

  logic [N-1:0] acc = '0;
  int n_timeouts = 0;
  int cyc = 0;
  int last_pulse_cyc = -1;
  logic [W-1:0] sent[$];
  int rem[N] = '{default: 0};
  int pause[N] = '{default: 0};
  int stall = 0;

  always #5 sysclk = ~sysclk;

  uart_tx_arbiter #(.NUM_REQ(N), .HOLD_TIMEOUT(T), .DATA_W(W)) dut (
    .sysclk        (sysclk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data),
    .tx_ready      (tx_ready),
    .grant_id      (grant_id),
    .busy          (busy),
    .timeout_pulse (timeout_pulse)
  );

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] exp_rdy;
    exp_rdy = '0;
    expect_eq("busy", busy, m_owner >= 0);
    expect_eq("grant_id", grant_id, m_gid);
    expect_eq("timeout_pulse", timeout_pulse, m_pulse);
    if (m_owner >= 0) begin
      exp_rdy[m_owner] = tx_ready;
      expect_eq("tx_valid", tx_valid, req_valid[m_owner]);
      expect_eq("tx_data", tx_data, req_data[m_owner*W +: W]);
    end else begin
      expect_eq("tx_valid", tx_valid, 1'b0);
    end
    expect_eq("req_ready", req_ready, exp_rdy);
  endtask

  task automatic model_step();
    m_pulse = 1'b0;
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        if (req_valid[(m_ptr + k) % N]) begin
          m_owner  = (m_ptr + k) % N;
          m_gid    = m_owner;
          m_silent = 0;
          break;
        end
      end
    end else if (req_valid[m_owner] && tx_ready) begin
      m_silent = 0;
      if (req_last[m_owner]) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
    end else if (!req_valid[m_owner]) begin
      m_silent++;
      if (m_silent == T) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_pulse = 1'b1;
      end
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_gid = 0; m_ptr = 0; m_silent = 0; m_pulse = 1'b0;
  endtask

  // Inputs are driven 1 ns after the rising edge; outputs are judged at the falling edge.
  task automatic cycle();
    @(negedge sysclk);
    cyc++;
    check_outputs();
    acc = req_valid & req_ready;
    if (tx_valid === 1'b1 && tx_ready === 1'b1) sent.push_back(tx_data);
    if (timeout_pulse === 1'b1) begin
      n_timeouts++;
      last_pulse_cyc = cyc;
    end
    @(posedge sysclk);
    model_step();
    #1;
  endtask

  task automatic send_byte(input int i, input logic [W-1:0] d, input logic l);
    bit done;
    done = 1'b0;
    req_valid[i] = 1'b1;
    req_data[i*W +: W] = d;
    req_last[i] = l;
    for (int n = 0; n < 100 && !done; n++) begin
      cycle();
      done = acc[i];
    end
    expect_eq($sformatf("accept_req%0d", i), done, 1'b1);
    req_valid[i] = 1'b0;
    req_last[i] = 1'b0;
  endtask

  task automatic rand_drive();
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        req_valid[i] = 1'b0;
        req_last[i] = 1'b0;
        rem[i]--;
        if (rem[i] > 0 && $urandom_range(0, 15) == 0) pause[i] = $urandom_range(8, 24);
      end
      if (!req_valid[i]) begin
        if (pause[i] > 0) pause[i]--;
        else begin
          if (rem[i] <= 0 && $urandom_range(0, 3) == 0) rem[i] = $urandom_range(1, 4);
          if (rem[i] > 0 && $urandom_range(0, 2) != 0) begin
            req_valid[i] = 1'b1;
            req_data[i*W +: W] = W'($urandom);
            req_last[i] = (rem[i] == 1);
          end
        end
      end
    end
    if (stall > 0) begin
      stall--;
      tx_ready = 1'b0;
    end else if ($urandom_range(0, 199) == 0) begin
      stall = 40;
      tx_ready = 1'b0;
    end else begin
      tx_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  initial begin
    int drop_cyc;
    // Reset and idle
    repeat (3) @(negedge sysclk);
    expect_eq("rst_tx_valid", tx_valid, 1'b0);
    expect_eq("rst_tx_data", tx_data, '0);
    expect_eq("rst_req_ready", req_ready, '0);
    expect_eq("rst_busy", busy, 1'b0);
    expect_eq("rst_grant_id", grant_id, '0);
    expect_eq("rst_timeout", timeout_pulse, 1'b0);
    rst_n = 1'b1;
    @(posedge sysclk);
    #1;
    repeat (2) cycle();

    // Single packet from requester 2
    tx_ready = 1'b1;
    sent.delete();
    send_byte(2, 8'h48, 1'b0);
    send_byte(2, 8'h69, 1'b1);
    cycle();
    expect_eq("t2_count", sent.size(), 2);
    if (sent.size() == 2) begin
      expect_eq("t2_byte0", sent[0], 8'h48);
      expect_eq("t2_byte1", sent[1], 8'h69);
    end
    expect_eq("t2_grant", grant_id, 2'd2);

    // Downstream stall: requester holds valid, no watchdog release
    tx_ready = 1'b0;
    req_valid[0] = 1'b1;
    req_data[0 +: W] = 8'h33;
    req_last[0] = 1'b1;
    repeat (41) cycle();
    tx_ready = 1'b1;
    send_byte(0, 8'h33, 1'b1);
    expect_eq("t4_no_timeout", n_timeouts, 0);
    cycle();

    // Requester stall: req 1 goes silent, pending req 2 takes over
    send_byte(1, 8'h10, 1'b0);
    drop_cyc = cyc + 1;
    send_byte(2, 8'hA5, 1'b1);
    expect_eq("t5_timeouts", n_timeouts, 1);
    expect_eq("t5_pulse_delay", last_pulse_cyc - drop_cyc, 16);
    cycle();

    // Async reset mid-packet
    req_valid[3] = 1'b1;
    req_data[3*W +: W] = 8'h77;
    req_last[3] = 1'b0;
    repeat (2) cycle();
    expect_eq("t6_busy_before", busy, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    expect_eq("t6_tx_valid", tx_valid, 1'b0);
    expect_eq("t6_tx_data", tx_data, '0);
    expect_eq("t6_req_ready", req_ready, '0);
    expect_eq("t6_busy", busy, 1'b0);
    expect_eq("t6_grant_id", grant_id, '0);
    model_reset();
    @(posedge sysclk);
    #1;
    rst_n = 1'b1;
    req_valid[3] = 1'b1;
    req_valid[1] = 1'b1;
    req_data[1*W +: W] = 8'h5A;
    req_last[1] = 1'b1;
    cycle();
    cycle();
    expect_eq("t6_regrant", grant_id, 2'd1);
    req_valid = '0;
    req_last = '0;
    repeat (2) cycle();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      cycle();
      rand_drive();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
